cr_huf_comp_st_lut_buf: RTL and testbench

Double-buffered holding store for the small-tree code-length (STCL) header words written by the STCL builder stage. Each completed table is captured into one of two banks, together with its STCL bit size and HCLEN. The stream assembler then drains it as a valid/ready word stream with per-word valid-bit counts. The builder can fill the next table while the previous one is still draining.

---
 rtl/cr_huf_compPKG.sv | 55 +++++
 rtl/cr_huf_comp_st_lut_bank.sv | 82 ++++++++
 rtl/cr_huf_comp_st_lut_buf.sv | 168 ++++++++++++++++
 tb/tb_cr_huf_comp_st_lut_buf.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_huf_compPKG.sv
// Shared types and helpers for the STCL header double buffer.
// Bank state, per-table metadata and word/bit arithmetic.
package cr_huf_compPKG;

    localparam int HDR_WIDTH = 64;
    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 2;
    localparam int SIZE_W    = 8;
    localparam int HCLEN_W   = 4;
    localparam int BITS_W    = $clog2(HDR_WIDTH) + 1;
    localparam int NW_W      = ADDR_W + 1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } e_st_buf_bank_state;

    typedef struct packed {
        logic [SIZE_W-1:0]  size;
        logic [HCLEN_W-1:0] hclen;
        logic [NW_W-1:0]    nwords;
    } s_st_buf_meta;

    // Words in a table: at least one, at most a full bank.
    function automatic logic [NW_W-1:0] st_nwords(
        input logic [SIZE_W-1:0] size
    );
        int n;
        n = (int'(size) + HDR_WIDTH - 1) / HDR_WIDTH;
        if (n < 1)
            n = 1;
        if (n > DEPTH)
            n = DEPTH;
        return NW_W'(n);
    endfunction

    // Valid bits of word k: full words, then the remainder.
    function automatic logic [BITS_W-1:0] st_word_bits(
        input s_st_buf_meta      m,
        input logic [ADDR_W-1:0] k
    );
        int rem;
        if (int'(k) + 1 < int'(m.nwords))
            return BITS_W'(HDR_WIDTH);
        rem = int'(m.size) - (int'(m.nwords) - 1) * HDR_WIDTH;
        if (rem > HDR_WIDTH)
            rem = HDR_WIDTH;
        if (rem < 0)
            rem = 0;
        return BITS_W'(rem);
    endfunction

endpackage

// File: rtl/cr_huf_comp_st_lut_bank.sv
// One STCL bank: word storage, table metadata and bank state.
// Writes and done are ignored unless the bank is free.
module cr_huf_comp_st_lut_bank
    import cr_huf_compPKG::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [HDR_WIDTH-1:0] wr_data_i,
    input  logic                 done_i,
    input  s_st_buf_meta         meta_i,
    input  logic                 drain_i,
    input  logic                 last_acc_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [HDR_WIDTH-1:0] rd_data_o,
    output s_st_buf_meta         meta_o,
    output logic                 free_o,
    output logic                 full_o,
    output logic                 busy_nxt_o
);

    e_st_buf_bank_state   state_q;
    e_st_buf_bank_state   state_d;
    s_st_buf_meta         meta_q;
    logic [HDR_WIDTH-1:0] mem_q [DEPTH];
    logic                 wr_ok;
    logic                 done_ok;

    assign free_o  = (state_q == EMPTY) || (state_q == FILLING);
    assign full_o  = (state_q == FULL);
    assign wr_ok   = wr_i && free_o;
    assign done_ok = done_i && free_o;

    assign busy_nxt_o = (state_d == FULL) || (state_d == DRAINING);
    assign rd_data_o  = mem_q[rd_addr_i];
    assign meta_o     = meta_q;

    // Bank lifecycle: fill, close, drain, release.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (done_i)
                    state_d = FULL;
                else if (wr_i)
                    state_d = FILLING;
            end
            FILLING: begin
                if (done_i)
                    state_d = FULL;
            end
            FULL: begin
                if (drain_i)
                    state_d = DRAINING;
            end
            DRAINING: begin
                if (last_acc_i)
                    state_d = EMPTY;
            end
        endcase
    end

    // State and metadata registers; meta captured on close.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            meta_q  <= '0;
        end else begin
            state_q <= state_d;
            if (done_ok)
                meta_q <= meta_i;
        end
    end

    // Word storage; contents survive reset, state does not.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem_q[wr_addr_i] <= wr_data_i;
    end

endmodule

// File: rtl/cr_huf_comp_st_lut_buf.sv
// Double-buffered STCL header store between builder and assembler.
// Bank pointers, registered word stream and word/bit arithmetic.
module cr_huf_comp_st_lut_buf
    import cr_huf_compPKG::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 st_lut_wr,
    input  logic [ADDR_W-1:0]    st_lut_wr_addr,
    input  logic [HDR_WIDTH-1:0] st_lut_wr_data,
    input  logic                 st_lut_wr_done,
    input  logic [SIZE_W-1:0]    st_lut_stcl_size,
    input  logic [HCLEN_W-1:0]   st_lut_hclen,
    output logic                 buf_full,
    output logic                 buf_ovfl,
    output logic                 sa_st_valid,
    input  logic                 sa_st_ready,
    output logic [HDR_WIDTH-1:0] sa_st_data,
    output logic [BITS_W-1:0]    sa_st_bits,
    output logic                 sa_st_last,
    output logic [SIZE_W-1:0]    sa_st_size,
    output logic [HCLEN_W-1:0]   sa_st_hclen
);

    logic [1:0]                 free;
    logic [1:0]                 full;
    logic [1:0]                 busy_nxt;
    logic [1:0]                 wr_en;
    logic [1:0]                 done_en;
    logic [1:0]                 drain;
    logic [1:0]                 last_acc;
    logic [1:0][HDR_WIDTH-1:0]  rd_data;
    s_st_buf_meta               meta [2];
    s_st_buf_meta               meta_in;

    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 valid_q, valid_d;
    logic [HDR_WIDTH-1:0] data_q, data_d;
    logic [BITS_W-1:0]    bits_q, bits_d;
    logic                 last_q, last_d;
    logic [SIZE_W-1:0]    size_q, size_d;
    logic [HCLEN_W-1:0]   hclen_q, hclen_d;
    logic [ADDR_W-1:0]    widx_q, widx_d;
    logic                 ovfl_q, ovfl_d;
    logic                 full_q, full_d;

    logic                 tgt_free;
    logic                 accept;
    logic                 fin;
    logic                 cand;
    logic                 start;
    logic                 adv;
    logic                 src;
    logic [ADDR_W-1:0]    rd_addr;
    logic [NW_W-1:0]      nxt_cnt;
    s_st_buf_meta         src_meta;

    assign meta_in.size   = st_lut_stcl_size;
    assign meta_in.hclen  = st_lut_hclen;
    assign meta_in.nwords = st_nwords(st_lut_stcl_size);

    assign tgt_free = free[wr_bank_q];
    assign ovfl_d   = (st_lut_wr || st_lut_wr_done) && !tgt_free;
    assign wr_bank_d = (st_lut_wr_done && tgt_free) ? ~wr_bank_q
                                                    : wr_bank_q;

    // Next table can start in the same cycle the current one ends.
    assign accept  = valid_q && sa_st_ready;
    assign fin     = accept && last_q;
    assign adv     = accept && !last_q;
    assign cand    = fin ? ~rd_bank_q : rd_bank_q;
    assign start   = (!valid_q || fin) && full[cand];
    assign src     = start ? cand : rd_bank_q;
    assign rd_addr = start ? '0 : widx_q + 1'b1;
    assign nxt_cnt = {1'b0, rd_addr} + 1'b1;
    assign src_meta  = meta[src];
    assign rd_bank_d = fin ? ~rd_bank_q : rd_bank_q;
    assign full_d    = busy_nxt[0] && busy_nxt[1];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic ID = 1'(b);
        assign wr_en[b]    = st_lut_wr && (wr_bank_q == ID);
        assign done_en[b]  = st_lut_wr_done && (wr_bank_q == ID);
        assign drain[b]    = start && (cand == ID);
        assign last_acc[b] = fin && (rd_bank_q == ID);

        cr_huf_comp_st_lut_bank u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_i       (wr_en[b]),
            .wr_addr_i  (st_lut_wr_addr),
            .wr_data_i  (st_lut_wr_data),
            .done_i     (done_en[b]),
            .meta_i     (meta_in),
            .drain_i    (drain[b]),
            .last_acc_i (last_acc[b]),
            .rd_addr_i  (rd_addr),
            .rd_data_o  (rd_data[b]),
            .meta_o     (meta[b]),
            .free_o     (free[b]),
            .full_o     (full[b]),
            .busy_nxt_o (busy_nxt[b])
        );
    end

    // Output word: load a new table, advance, hold or go idle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bits_d  = bits_q;
        last_d  = last_q;
        size_d  = size_q;
        hclen_d = hclen_q;
        widx_d  = widx_q;
        if (start || adv) begin
            valid_d = 1'b1;
            widx_d  = rd_addr;
            data_d  = (src_meta.size == '0) ? '0 : rd_data[src];
            bits_d  = st_word_bits(src_meta, rd_addr);
            last_d  = (nxt_cnt == src_meta.nwords);
            size_d  = src_meta.size;
            hclen_d = src_meta.hclen;
        end else if (fin) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Pointer, status and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            bits_q    <= '0;
            last_q    <= 1'b0;
            size_q    <= '0;
            hclen_q   <= '0;
            widx_q    <= '0;
            ovfl_q    <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            bits_q    <= bits_d;
            last_q    <= last_d;
            size_q    <= size_d;
            hclen_q   <= hclen_d;
            widx_q    <= widx_d;
            ovfl_q    <= ovfl_d;
            full_q    <= full_d;
        end
    end

    assign buf_full    = full_q;
    assign buf_ovfl    = ovfl_q;
    assign sa_st_valid = valid_q;
    assign sa_st_data  = data_q;
    assign sa_st_bits  = bits_q;
    assign sa_st_last  = last_q;
    assign sa_st_size  = size_q;
    assign sa_st_hclen = hclen_q;

endmodule

// File: tb/tb_cr_huf_comp_st_lut_buf.sv
// Bench for the STCL double buffer.
// Reference: queue of expected words plus a count of held tables.
module tb_cr_huf_comp_st_lut_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_lut_wr;
    logic [1:0]  st_lut_wr_addr;
    logic [63:0] st_lut_wr_data;
    logic        st_lut_wr_done;
    logic [7:0]  st_lut_stcl_size;
    logic [3:0]  st_lut_hclen;
    logic        buf_full;
    logic        buf_ovfl;
    logic        sa_st_valid;
    logic        sa_st_ready;
    logic [63:0] sa_st_data;
    logic [6:0]  sa_st_bits;
    logic        sa_st_last;
    logic [7:0]  sa_st_size;
    logic [3:0]  sa_st_hclen;

    cr_huf_comp_st_lut_buf dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .st_lut_wr        (st_lut_wr),
        .st_lut_wr_addr   (st_lut_wr_addr),
        .st_lut_wr_data   (st_lut_wr_data),
        .st_lut_wr_done   (st_lut_wr_done),
        .st_lut_stcl_size (st_lut_stcl_size),
        .st_lut_hclen     (st_lut_hclen),
        .buf_full         (buf_full),
        .buf_ovfl         (buf_ovfl),
        .sa_st_valid      (sa_st_valid),
        .sa_st_ready      (sa_st_ready),
        .sa_st_data       (sa_st_data),
        .sa_st_bits       (sa_st_bits),
        .sa_st_last       (sa_st_last),
        .sa_st_size       (sa_st_size),
        .sa_st_hclen      (sa_st_hclen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          bits;
        bit          last;
        int          size;
        int          hclen;
        int          done_cyc;
        int          widx;
    } word_t;

    word_t       expq [$];
    logic [63:0] fill [4];
    int          held = 0;
    int          cyc = 0;
    bit          exp_valid = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)",
                   tag, got, exp, cyc);
        end
    endtask

    function automatic bit rdy_of(input int mode);
        if (mode == 0)
            return 1'b1;
        if (mode == 2)
            return 1'b0;
        return 1'($urandom % 2);
    endfunction

    // Expected words of a closed table from its size alone.
    function automatic void push_table(input int size, input int hclen);
        int n;
        n = (size == 0) ? 1 : (size + 63) / 64;
        if (n > 4)
            n = 4;
        for (int k = 0; k < n; k++) begin
            word_t w;
            w.data     = (size == 0) ? 64'h0 : fill[k];
            w.bits     = (k < n - 1) ? 64 : size - (n - 1) * 64;
            w.last     = (k == n - 1);
            w.size     = size;
            w.hclen    = hclen;
            w.done_cyc = cyc;
            w.widx     = k;
            expq.push_back(w);
        end
    endfunction

    task automatic step(input bit wr, input int addr,
                        input logic [63:0] d, input bit done,
                        input int size, input int hclen,
                        input bit rdy);
        bit busy;
        bit acc;
        st_lut_wr        = wr;
        st_lut_wr_addr   = addr[1:0];
        st_lut_wr_data   = d;
        st_lut_wr_done   = done;
        st_lut_stcl_size = size[7:0];
        st_lut_hclen     = hclen[3:0];
        sa_st_ready      = rdy;
        @(posedge clk);
        cyc++;
        busy = (held == 2);
        acc  = exp_valid && rdy;
        if (acc) begin
            if (expq[0].last)
                held--;
            void'(expq.pop_front());
        end
        if (!busy && wr)
            fill[addr] = d;
        if (!busy && done) begin
            push_table(size, hclen);
            held++;
        end
        #1;
        chk("ovfl", 64'(buf_ovfl), 64'((wr || done) && busy));
        chk("full", 64'(buf_full), 64'(held == 2));
        exp_valid = (expq.size() > 0) && (expq[0].done_cyc < cyc);
        chk("valid", 64'(sa_st_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("data", sa_st_data, expq[0].data);
            chk("bits", 64'(sa_st_bits), 64'(expq[0].bits));
            chk("last", 64'(sa_st_last), 64'(expq[0].last));
            chk("size", 64'(sa_st_size), 64'(expq[0].size));
            chk("hclen", 64'(sa_st_hclen), 64'(expq[0].hclen));
        end
    endtask

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++)
            step(0, 0, 64'h0, 0, 0, 0, rdy_of(mode));
    endtask

    task automatic drain(input int mode);
        for (int i = 0; i < 200 && expq.size() > 0; i++)
            step(0, 0, 64'h0, 0, 0, 0, rdy_of(mode));
        idle(2, mode);
    endtask

    task automatic write_table(input int size, input int hclen,
                               input logic [63:0] d0,
                               input int mode, input bit sep);
        int n;
        n = (size == 0) ? 0 : (size + 63) / 64;
        for (int k = 0; k < n; k++)
            step(1, k, (k == 0) ? d0 : {$urandom, $urandom},
                 (k == n - 1) && !sep, size, hclen, rdy_of(mode));
        if (n == 0 || sep)
            step(0, 0, 64'h0, 1, size, hclen, rdy_of(mode));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 64'(sa_st_valid), 64'h0);
        chk({tag, "_data"}, sa_st_data, 64'h0);
        chk({tag, "_bits"}, 64'(sa_st_bits), 64'h0);
        chk({tag, "_last"}, 64'(sa_st_last), 64'h0);
        chk({tag, "_size"}, 64'(sa_st_size), 64'h0);
        chk({tag, "_hclen"}, 64'(sa_st_hclen), 64'h0);
        chk({tag, "_full"}, 64'(buf_full), 64'h0);
        chk({tag, "_ovfl"}, 64'(buf_ovfl), 64'h0);
    endtask

    initial begin
        int sizes [6];
        sizes = '{64, 65, 128, 192, 255, 1};
        rst_n            = 1'b0;
        st_lut_wr        = 1'b0;
        st_lut_wr_addr   = '0;
        st_lut_wr_data   = '0;
        st_lut_wr_done   = 1'b0;
        st_lut_stcl_size = '0;
        st_lut_hclen     = '0;
        sa_st_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-word deflate table, write and done together.
        write_table(57, 14, 64'h01C0_FFEE_DEAD_BEEF, 0, 0);
        idle(3, 0);

        // Three-word raw table, separate done.
        write_table(132, 9, {$urandom, $urandom}, 0, 1);
        idle(5, 0);

        // Backpressure on word 2.
        write_table(132, 5, {$urandom, $urandom}, 2, 0);
        for (int i = 0; i < 10 && expq.size() > 0 && expq[0].widx == 0; i++)
            idle(1, 0);
        idle(5, 2);
        drain(0);

        // Ping-pong: B closes while A drains.
        write_table(100, 3, {$urandom, $urandom}, 2, 0);
        write_table(40, 7, {$urandom, $urandom}, 1, 0);
        idle(2, 2);
        drain(1);

        // Overflow: both banks held, extra write and done dropped.
        write_table(64, 1, {$urandom, $urandom}, 2, 0);
        write_table(20, 2, {$urandom, $urandom}, 2, 0);
        step(1, 0, {$urandom, $urandom}, 0, 0, 0, 0);
        step(0, 0, 64'h0, 1, 5, 8, 0);
        idle(1, 2);
        drain(0);

        // Empty table.
        write_table(0, 4, {$urandom, $urandom}, 0, 0);
        drain(0);

        // Boundary sizes, then random tables with random ready.
        for (int t = 0; t < 22; t++) begin
            int sz;
            sz = (t < 6) ? sizes[t] : int'($urandom_range(0, 255));
            for (int i = 0; i < 50 && held == 2; i++)
                idle(1, 1);
            write_table(sz, int'($urandom_range(0, 15)),
                        {$urandom, $urandom}, 1, 1'($urandom % 2));
        end
        drain(1);

        // Reset in the middle of a three-word drain.
        write_table(150, 6, {$urandom, $urandom}, 2, 0);
        idle(2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("rst_mid");
        expq.delete();
        held      = 0;
        exp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(6, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
